mnist_wb_param_regs: RTL

- Wishbone classic slave register block; the responder for the testbench-side Wishbone master used by the MNIST video pipeline.
- Holds the binarization parameters (threshold, invert) as host-writable shadow registers.
- Shadow values are copied to the active outputs only at a video frame start, so parameters never change mid-frame.
- Optionally exposes frame and validation statistics counters.

---
 rtl/mnist_wb_param_regs.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mnist_wb_param_regs.sv
// mnist_wb_param_regs: Wishbone classic slave holding the binarization
// parameters (threshold, invert). Host writes land in shadow registers and
// are copied to the active outputs only at a video frame start.
// Optional statistics counters (FRAME_COUNT, VALID_COUNT) are built when the
// macro MNIST_PARAM_STAT_EN is defined; otherwise those addresses read 0.
module mnist_wb_param_regs #(
    parameter int                          WB_ADR_WIDTH   = 8,
    parameter int                          WB_DAT_WIDTH   = 32,
    parameter int                          WB_SEL_WIDTH   = WB_DAT_WIDTH / 8,
    parameter logic [WB_DAT_WIDTH-1:0]     CORE_ID        = 32'h527a_2f10,
    parameter int                          TH_WIDTH       = 8,
    parameter logic [TH_WIDTH-1:0]         INIT_PARAM_TH  = TH_WIDTH'(127),
    parameter logic                        INIT_PARAM_INV = 1'b0
) (
    input  logic                    clk,
    input  logic                    wb_rst_i,
    input  logic [WB_ADR_WIDTH-1:0] s_wb_adr_i,
    input  logic [WB_DAT_WIDTH-1:0] s_wb_dat_i,
    output logic [WB_DAT_WIDTH-1:0] s_wb_dat_o,
    input  logic                    s_wb_we_i,
    input  logic [WB_SEL_WIDTH-1:0] s_wb_sel_i,
    input  logic                    s_wb_stb_i,
    output logic                    s_wb_ack_o,
    input  logic                    cke,
    input  logic                    frame_start,
    input  logic                    validation,
    output logic [TH_WIDTH-1:0]     param_th,
    output logic                    param_inv,
    output logic                    update_ack
);

    localparam logic [WB_ADR_WIDTH-1:0] ADR_ID         = WB_ADR_WIDTH'(0);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_CONTROL    = WB_ADR_WIDTH'(1);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_SHADOW_TH  = WB_ADR_WIDTH'(4);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_SHADOW_INV = WB_ADR_WIDTH'(5);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_ACTIVE_TH  = WB_ADR_WIDTH'(8);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_ACTIVE_INV = WB_ADR_WIDTH'(9);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_FRAME_CNT  = WB_ADR_WIDTH'(12);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_VALID_CNT  = WB_ADR_WIDTH'(13);

    logic                    ack_reg;
    logic [WB_DAT_WIDTH-1:0] dat_reg;
    logic                    update_req_reg;
    logic                    auto_update_reg;
    logic [TH_WIDTH-1:0]     shadow_th_reg;
    logic                    shadow_inv_reg;
    logic [TH_WIDTH-1:0]     active_th_reg;
    logic                    active_inv_reg;
    logic                    update_ack_reg;

    logic                    access;
    logic                    wr_en;
    logic                    frame_evt;
    logic                    do_update;
    logic [TH_WIDTH-1:0]     th_lane_mask;
    logic [TH_WIDTH-1:0]     shadow_th_next;
    logic [WB_DAT_WIDTH-1:0] rd_data;
    logic                    unused_inputs;

    // Transfer accepted on the edge that raises ack (one wait state)
    assign access    = s_wb_stb_i & ~ack_reg;
    assign wr_en     = access & s_wb_we_i;
    assign frame_evt = cke & frame_start;
    assign do_update = frame_evt & (update_req_reg | auto_update_reg);

    // Each threshold bit is written only when its byte lane is selected
    generate
        for (genvar gi = 0; gi < TH_WIDTH; gi++) begin : g_th_mask
            assign th_lane_mask[gi] = s_wb_sel_i[gi / 8];
        end
    endgenerate

    assign shadow_th_next = (shadow_th_reg & ~th_lane_mask)
                          | (s_wb_dat_i[TH_WIDTH-1:0] & th_lane_mask);

    // Bits not decoded by any register are folded here to keep lint quiet
    assign unused_inputs = ^{s_wb_dat_i, s_wb_sel_i, validation};

`ifdef MNIST_PARAM_STAT_EN
    logic [WB_DAT_WIDTH-1:0] frame_count_reg;
    logic [WB_DAT_WIDTH-1:0] valid_count_reg;

    // Statistics counters; a host clear beats a same-edge increment
    always_ff @(posedge clk or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            frame_count_reg <= '0;
            valid_count_reg <= '0;
        end else begin
            if (wr_en && s_wb_adr_i == ADR_FRAME_CNT && |s_wb_sel_i)
                frame_count_reg <= '0;
            else if (frame_evt)
                frame_count_reg <= frame_count_reg + WB_DAT_WIDTH'(1);
            if (wr_en && s_wb_adr_i == ADR_VALID_CNT && |s_wb_sel_i)
                valid_count_reg <= '0;
            else if (cke & validation)
                valid_count_reg <= valid_count_reg + WB_DAT_WIDTH'(1);
        end
    end
`endif

    // Read multiplexer; unmapped addresses return zero
    always_comb begin
        rd_data = '0;
        case (s_wb_adr_i)
            ADR_ID:         rd_data = CORE_ID;
            ADR_CONTROL:    rd_data[1:0] = {auto_update_reg, update_req_reg};
            ADR_SHADOW_TH:  rd_data[TH_WIDTH-1:0] = shadow_th_reg;
            ADR_SHADOW_INV: rd_data[0] = shadow_inv_reg;
            ADR_ACTIVE_TH:  rd_data[TH_WIDTH-1:0] = active_th_reg;
            ADR_ACTIVE_INV: rd_data[0] = active_inv_reg;
`ifdef MNIST_PARAM_STAT_EN
            ADR_FRAME_CNT:  rd_data = frame_count_reg;
            ADR_VALID_CNT:  rd_data = valid_count_reg;
`endif
            default:        rd_data = '0;
        endcase
    end

    // Wishbone handshake: one-cycle ack, read data valid only with ack
    always_ff @(posedge clk or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            ack_reg <= 1'b0;
            dat_reg <= '0;
        end else begin
            ack_reg <= access;
            dat_reg <= access ? rd_data : '0;
        end
    end

    // Control, shadow and active parameters; copy uses pre-edge shadow
    always_ff @(posedge clk or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            update_req_reg  <= 1'b0;
            auto_update_reg <= 1'b0;
            shadow_th_reg   <= INIT_PARAM_TH;
            shadow_inv_reg  <= INIT_PARAM_INV;
            active_th_reg   <= INIT_PARAM_TH;
            active_inv_reg  <= INIT_PARAM_INV;
            update_ack_reg  <= 1'b0;
        end else begin
            update_ack_reg <= do_update;
            if (do_update) begin
                active_th_reg  <= shadow_th_reg;
                active_inv_reg <= shadow_inv_reg;
            end
            // A host write to CONTROL overrides the frame-start clear
            if (wr_en && s_wb_adr_i == ADR_CONTROL && s_wb_sel_i[0]) begin
                update_req_reg  <= s_wb_dat_i[0];
                auto_update_reg <= s_wb_dat_i[1];
            end else if (do_update) begin
                update_req_reg <= 1'b0;
            end
            if (wr_en && s_wb_adr_i == ADR_SHADOW_TH)
                shadow_th_reg <= shadow_th_next;
            if (wr_en && s_wb_adr_i == ADR_SHADOW_INV && s_wb_sel_i[0])
                shadow_inv_reg <= s_wb_dat_i[0];
        end
    end

    assign s_wb_ack_o = ack_reg;
    assign s_wb_dat_o = dat_reg;
    assign param_th   = active_th_reg;
    assign param_inv  = active_inv_reg;
    assign update_ack = update_ack_reg;

endmodule
